frame_compare_ctrl: RTL
=======================

Name: frame_compare_ctrl

Overview:
- Hardware controller that sequences a pixel-by-pixel comparison of two 12-bit image streams: stream A is design output, stream B is golden/reference image data.
- Joins both streams with valid/ready handshakes and counts one frame of NUM_PIX pixels.
- Records mismatch statistics and the first mismatch, and reports pass/fail once per frame.
- Sits between the convolution/buffer output and the golden-image source in the self-check path.

Parameters:
- DATA_W, 12, pixel width in bits.
- NUM_PIX, 4096, pixels per frame; must be >= 2.
- CNT_W, 13, width of the pixel index and error counters; must satisfy 2^CNT_W > NUM_PIX.
- TIMEOUT, 1024, consecutive RUN cycles with no transfer before the frame aborts; must be >= 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active high.
- start  in  1  single-cycle pulse that begins a frame comparison; honoured only in IDLE.
- a_data  in  DATA_W  stream A pixel.
- a_valid  in  1  stream A pixel is valid.
- a_ready  out  1  stream A pixel is accepted this cycle.
- b_data  in  DATA_W  stream B (golden) pixel.
- b_valid  in  1  stream B pixel is valid.
- b_ready  out  1  stream B pixel is accepted this cycle.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at frame end.
- pass  out  1  frame result; meaningful from done until the next start.
- timeout  out  1  frame was aborted by the stall timer.
- pix_idx  out  CNT_W  number of pixel pairs consumed so far in the current frame.
- err_count  out  CNT_W  mismatch count; saturates at 2^CNT_W-1.
- first_err_idx  out  CNT_W  index of the first mismatching pixel.
- first_err_a  out  DATA_W  stream A value at the first mismatch.
- first_err_b  out  DATA_W  stream B value at the first mismatch.

Behaviour:
- States: IDLE, RUN, DONE. Reset and power-up state is IDLE.
- rst (synchronous) in any state, including mid-frame: next state IDLE. All outputs and counters go to 0 (pass=0, timeout=0). Any in-flight frame is discarded with no done pulse.
- IDLE, start=1: clear pix_idx, err_count, first_err_*, pass, timeout and the stall timer; go to RUN next cycle. start while in RUN or DONE is ignored.
- Handshake (combinational):
  - a_ready = (state==RUN) & b_valid
  - b_ready = (state==RUN) & a_valid
  - fire = (state==RUN) & a_valid & b_valid
  - Both streams advance together, and only on fire. Sources must not make valid depend on ready.
- Outside RUN, a_ready = b_ready = 0.
- On fire, mismatch = (a_data != b_data):
  - pix_idx increments.
  - On mismatch, err_count increments, saturating.
  - If err_count==0 before the increment, capture first_err_idx=pix_idx (pre-increment value), first_err_a=a_data, first_err_b=b_data. Later mismatches never overwrite these captures.
- Frame end: a fire with pix_idx==NUM_PIX-1 moves the state to DONE.
- Stall timer:
  - Counts RUN cycles without a fire; cleared on every fire.
  - When it reaches TIMEOUT-1 and the current cycle has no fire: go to DONE with timeout=1.
  - If a fire and expiry coincide, the fire wins and the timer clears.
- DONE, one cycle:
  - done=1; pass = (err_count==0) & ~timeout, where err_count includes the final pixel.
  - Next state IDLE.
  - pass, timeout, err_count, pix_idx and first_err_* hold until the next accepted start or rst.
- Latency: done is asserted the cycle after the last fire. Minimum frame duration is 1 (start) + NUM_PIX + 1 cycles.
- busy = (state==RUN).
- Error counter saturation: err_count holds at all-ones and does not wrap.

Test Plan:
- Bench overrides: NUM_PIX=8, TIMEOUT=16, CNT_W=4.
- Matched frame: both streams send 0x000..0x007 with valid held high -> a_ready/b_ready high for 8 cycles, pix_idx=8, done on the cycle after the 8th fire, pass=1, err_count=0, timeout=0.
- Two mismatches: A=B except idx 3 (A=0xABC, B=0xABD) and idx 6 -> err_count=2, first_err_idx=3, first_err_a=0xABC, first_err_b=0xABD, pass=0.
- Skewed valids: A valid every cycle, B valid on alternate cycles -> fire only when both are valid, a_ready low whenever b_valid=0, 8 transfers and correct pass, no timeout.
- Stall: B stops after 5 pixels -> done exactly 16 RUN cycles after the last fire, timeout=1, pass=0, pix_idx=5.
- Reset mid-frame: rst asserted after 4 fires -> next cycle state IDLE with all outputs 0 and no done pulse. A new start then runs a full clean frame with pass=1.
- start while busy: pulse start mid-frame -> ignored, counters continue, single done pulse at frame end.

Source files
------------

// File: rtl/frame_compare_ctrl.sv
// frame_compare_ctrl: joins a design pixel stream (A) with a golden stream (B),
// compares one frame of NUM_PIX pixel pairs and reports mismatch statistics,
// the first mismatch and a per-frame pass/fail, with a stall timer that aborts
// a frame when no pair has transferred for TIMEOUT consecutive cycles.
module frame_compare_ctrl #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned NUM_PIX = 4096,
    parameter int unsigned CNT_W   = 13,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_valid,
    output logic              b_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  pix_idx,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_a,
    output logic [DATA_W-1:0] first_err_b
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIX - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   pix_q, pix_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   fidx_q, fidx_d;
    logic [DATA_W-1:0]  fa_q, fa_d;
    logic [DATA_W-1:0]  fb_q, fb_d;
    logic               pass_q, pass_d;
    logic               tout_q, tout_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;

    logic run;
    logic fire;

    assign run     = (state_q == S_RUN);
    assign fire    = run & a_valid & b_valid;
    assign a_ready = run & b_valid;
    assign b_ready = run & a_valid;
    assign busy    = run;
    assign done    = (state_q == S_DONE);

    assign pass          = pass_q;
    assign timeout       = tout_q;
    assign pix_idx       = pix_q;
    assign err_count     = err_q;
    assign first_err_idx = fidx_q;
    assign first_err_a   = fa_q;
    assign first_err_b   = fb_q;

    // State register and all frame statistics; rst discards any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            pass_q  <= 1'b0;
            tout_q  <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            pass_q  <= pass_d;
            tout_q  <= tout_d;
            tmr_q   <= tmr_d;
        end
    end

    // Next-state: start clears statistics, each fire updates them, frame end or stall expiry ends the frame.
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        pass_d  = pass_q;
        tout_d  = tout_q;
        tmr_d   = tmr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pix_d   = '0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fa_d    = '0;
                    fb_d    = '0;
                    pass_d  = 1'b0;
                    tout_d  = 1'b0;
                    tmr_d   = '0;
                end
            end

            S_RUN: begin
                if (fire) begin
                    pix_d = pix_q + 1'b1;
                    tmr_d = '0;
                    if (a_data != b_data) begin
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        if (err_q == '0) begin
                            fidx_d = pix_q;
                            fa_d   = a_data;
                            fb_d   = b_data;
                        end
                    end
                    if (pix_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    state_d = S_DONE;
                    tout_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
                // Result is latched on entry to DONE so it already reflects the final pixel.
                if (state_d == S_DONE) begin
                    pass_d = (err_d == '0) & ~tout_d;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
